regfile_stream: RTL and testbench



---
 rtl/regfile_stream_if.sv | 26 ++
 rtl/regfile_stream.sv | 81 ++++++++
 tb/tb_regfile_stream.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_stream_if.sv
// regfile_stream_if: write, read and scan signal bundle for regfile_stream
interface regfile_stream_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  logic             ena;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             scan_start;
  logic             scan_busy;
  logic             scan_valid;
  logic [AW-1:0]    scan_addr;
  logic [WIDTH-1:0] scan_data;
  modport master (
    output ena, wr_en, wr_addr, wr_data, rd_addr, scan_start,
    input  rd_data, scan_busy, scan_valid, scan_addr, scan_data
  );
  modport slave (
    input  ena, wr_en, wr_addr, wr_data, rd_addr, scan_start,
    output rd_data, scan_busy, scan_valid, scan_addr, scan_data
  );
endinterface

// File: rtl/regfile_stream.sv
// regfile_stream: register bank with one write port, a registered read port and a full-bank scan streamer; define REGFILE_BYPASS_EN for write-first forwarding
module regfile_stream #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  regfile_stream_if.slave bus
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    scan_addr_q, scan_addr_d;
  logic             scan_valid_q, scan_valid_d;
  logic [WIDTH-1:0] scan_data_q, scan_data_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic [WIDTH-1:0] scan_rd;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_hit;
  assign wr_hit = bus.ena && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W);
  // storage: out-of-range write addresses never reach the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    else if (wr_hit) mem_q[bus.wr_addr] <= bus.wr_data;
  end
  // array reads for both ports; the forwarding mux exists only in bypass builds
  always_comb begin
    rd_d    = ({1'b0, bus.rd_addr} < DEPTH_W) ? mem_q[bus.rd_addr] : '0;
    scan_rd = mem_q[ptr_q];
`ifdef REGFILE_BYPASS_EN
    rd_d    = (wr_hit && bus.wr_addr == bus.rd_addr) ? bus.wr_data : rd_d;
    scan_rd = (wr_hit && bus.wr_addr == ptr_q) ? bus.wr_data : scan_rd;
`else
`endif
  end
  // scan sequencing: ptr wraps explicitly at DEPTH-1; everything holds while ena is low
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    scan_valid_d = scan_valid_q;
    scan_addr_d  = scan_addr_q;
    scan_data_d  = scan_data_q;
    if (bus.ena && state_q == IDLE) begin
      scan_valid_d = 1'b0;
      state_d      = bus.scan_start ? SCAN : IDLE;
      ptr_d        = '0;
    end else if (bus.ena) begin
      scan_valid_d = 1'b1;
      scan_addr_d  = ptr_q;
      scan_data_d  = scan_rd;
      state_d      = (ptr_q == LAST) ? IDLE : SCAN;
      ptr_d        = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end
  // state, scan output and read data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      scan_valid_q <= 1'b0;
      scan_addr_q  <= '0;
      scan_data_q  <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      scan_valid_q <= scan_valid_d;
      scan_addr_q  <= scan_addr_d;
      scan_data_q  <= scan_data_d;
      if (bus.ena) rd_q <= rd_d;
    end
  end
  assign bus.rd_data    = rd_q;
  assign bus.scan_busy  = (state_q == SCAN);
  assign bus.scan_valid = scan_valid_q;
  assign bus.scan_addr  = scan_addr_q;
  assign bus.scan_data  = scan_data_q;
endmodule

// File: tb/tb_regfile_stream.sv
// tb_regfile_stream: directed and random stimulus against a queue-based reference model of regfile_stream
module tb_regfile_stream;
  localparam int W  = 4;
  localparam int D  = 5;
  localparam int AW = $clog2(D);
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_checks = 0;
  int n_fails = 0;
  regfile_stream_if #(.WIDTH(W), .DEPTH(D)) bus ();
  regfile_stream #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [W-1:0]  mem [D];
  logic [W-1:0]  m_rd, m_sd;
  logic [AW-1:0] m_sa;
  logic          m_sv, m_busy;
  int            pend[$];
  logic [W-1:0]  dvals [D];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(m_rd));
    check({tag, ".scan_busy"}, 32'(bus.scan_busy), 32'(m_busy));
    check({tag, ".scan_valid"}, 32'(bus.scan_valid), 32'(m_sv));
    check({tag, ".scan_addr"}, 32'(bus.scan_addr), 32'(m_sa));
    check({tag, ".scan_data"}, 32'(bus.scan_data), 32'(m_sd));
  endtask

  task automatic model_reset();
    foreach (mem[k]) mem[k] = '0;
    m_rd = '0; m_sd = '0; m_sa = '0; m_sv = 1'b0; m_busy = 1'b0;
    pend.delete();
  endtask

  task automatic model_edge();
    logic [W-1:0] new_rd;
    logic wr_hit;
    int a;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!bus.ena) return;
    wr_hit = bus.wr_en && int'(bus.wr_addr) < D;
    new_rd = (int'(bus.rd_addr) < D) ? mem[int'(bus.rd_addr)] : '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_hit && bus.wr_addr == bus.rd_addr) new_rd = bus.wr_data;
`endif
    if (m_busy) begin
      a = pend.pop_front();
      m_sv = 1'b1;
      m_sa = AW'(a);
      m_sd = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && int'(bus.wr_addr) == a) m_sd = bus.wr_data;
`endif
      if (pend.size() == 0) m_busy = 1'b0;
    end else begin
      m_sv = 1'b0;
      if (bus.scan_start) begin
        for (int k = 0; k < D; k++) pend.push_back(k);
        m_busy = 1'b1;
      end
    end
    if (wr_hit) mem[int'(bus.wr_addr)] = bus.wr_data;
    m_rd = new_rd;
  endtask

  task automatic drive(input int e, input int we, input int wa, input int wd, input int ra, input int ss);
    bus.ena        = e[0];
    bus.wr_en      = we[0];
    bus.wr_addr    = AW'(wa);
    bus.wr_data    = W'(wd);
    bus.rd_addr    = AW'(ra);
    bus.scan_start = ss[0];
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    dvals = '{4'h3, 4'h5, 4'hA, 4'hF, 4'h6};
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("reset_async");
    step("reset_hold");
    step("reset_hold");
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      drive(1, 0, 0, 0, a, 0);
      step("read_zero");
      check("read_zero_dir", 32'(bus.rd_data), 32'h0);
    end
    for (int a = 0; a < D; a++) begin
      drive(1, 1, a, dvals[a], 0, 0);
      step("write");
    end
    drive(1, 0, 0, 0, 2, 0);
    step("read2");
    check("read2_dir", 32'(bus.rd_data), 32'hA);
    drive(1, 0, 0, 0, 3, 0);
    step("read3");
    check("read3_dir", 32'(bus.rd_data), 32'hF);
    drive(1, 1, 1, 9, 1, 0);
    step("collide");
`ifdef REGFILE_BYPASS_EN
    check("collide_dir", 32'(bus.rd_data), 32'h9);
`else
    check("collide_dir", 32'(bus.rd_data), 32'h5);
`endif
    drive(1, 0, 0, 0, 1, 0);
    step("collide_next");
    check("collide_next_dir", 32'(bus.rd_data), 32'h9);
    drive(1, 1, 1, 5, 0, 0);
    step("restore");
    drive(1, 0, 0, 0, 0, 1);
    step("scan_accept");
    check("scan_accept_busy", 32'(bus.scan_busy), 32'h1);
    for (int k = 1; k <= D + 2; k++) begin
      drive(1, 0, 0, 0, 0, (k == 2 || k == 4) ? 1 : 0);
      step("scan");
      check("scan_valid_dir", 32'(bus.scan_valid), (k <= D) ? 32'h1 : 32'h0);
      check("scan_busy_dir", 32'(bus.scan_busy), (k < D) ? 32'h1 : 32'h0);
      if (k <= D) begin
        check("scan_addr_dir", 32'(bus.scan_addr), 32'(k - 1));
        check("scan_data_dir", 32'(bus.scan_data), 32'(dvals[k-1]));
      end
    end
    drive(1, 1, 5, 7, 6, 0);
    step("oor_write");
    check("oor_read_dir", 32'(bus.rd_data), 32'h0);
    drive(1, 1, 7, 3, 5, 0);
    step("oor_write2");
    for (int a = 0; a < 8; a++) begin
      drive(1, 0, 0, 0, a, 0);
      step("readback");
    end
    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 0, 0, k % 8, 1);
      step("b2b_scan");
    end
    drive(1, 0, 0, 0, 0, 1);
    step("wscan_start");
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, $urandom_range(0, 7), $urandom, $urandom_range(0, 7), 0);
      step("wscan");
    end
    drive(1, 0, 0, 0, 0, 1);
    step("freeze_start");
    drive(1, 0, 0, 0, 0, 0);
    step("freeze_run");
    step("freeze_run");
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 2, 1, 3, 1);
      step("frozen");
    end
    rst_n = 1'b0;
    #1 model_reset();
    check_all("reset_mid");
    check("reset_mid_busy", 32'(bus.scan_busy), 32'h0);
    drive(1, 0, 0, 0, 0, 1);
    step("reset_mid_hold");
    rst_n = 1'b1;
    for (int a = 0; a < D; a++) begin
      drive(1, 0, 0, 0, a, 0);
      step("cleared");
      check("cleared_dir", 32'(bus.rd_data), 32'h0);
    end
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 9) != 0) ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom, $urandom_range(0, 7), ($urandom_range(0, 5) == 0) ? 1 : 0);
      step("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
